// File: rtl/fetch_frontend.sv
// Instruction-cache client: sequential PC fetch into a small decode FIFO, with
// load/store requests muxed onto the same cache command port (data has priority).
module fetch_frontend #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_inst_data,
    input  logic        i_dreq_valid,
    output logic        o_dreq_ready,
    input  logic        i_dreq_write,
    input  logic [31:0] i_dreq_addr,
    input  logic [31:0] i_dreq_wdata,
    input  logic [3:0]  i_dreq_wstrb,
    output logic        o_dresp_valid,
    output logic [31:0] o_dresp_rdata,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic [2:0]  o_cache_command,
    input  logic        i_cache_ready,
    input  logic        i_cache_hit,
    output logic [31:0] o_cache_inst_addr,
    output logic [31:0] o_cache_data_addr,
    output logic [31:0] o_cache_data_wdata,
    output logic [3:0]  o_cache_data_wstrb,
    input  logic [31:0] i_cache_inst_rdata,
    input  logic [31:0] i_cache_data_rdata,
    input  logic [1:0]  i_cache_error
);

    localparam int unsigned AW      = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT_INST,
        ST_WAIT_DATA,
        ST_FAULT
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_fifo_pc   [QUEUE_DEPTH];
    logic [31:0]   r_fifo_data [QUEUE_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_data_addr;
    logic [31:0]   r_data_wdata;
    logic [3:0]    r_data_wstrb;
    logic          r_data_write;
    logic          r_dresp_valid;
    logic [31:0]   r_dresp_rdata;
    logic          r_fault;
    logic [1:0]    r_fault_code;

    logic w_can_issue;
    logic w_data_issue;
    logic w_inst_issue;
    logic w_hit;
    logic w_flush;
    logic w_push;
    logic w_pop;
    logic w_error;

    // Fetch is throttled on the registered count only, so a pop in the same
    // cycle never lets an extra fetch slip in.
    always_comb begin
        w_can_issue  = (r_state == ST_FETCH) && i_cache_ready;
        w_data_issue = w_can_issue && i_dreq_valid;
        w_inst_issue = w_can_issue && !i_dreq_valid && (r_count < DEPTH_C);
        w_hit        = w_inst_issue && i_cache_hit;
        w_flush      = i_redirect_valid && (r_state != ST_FAULT);
        w_push       = w_hit && !w_flush;
        w_pop        = o_inst_valid && i_inst_ready;
        w_error      = (i_cache_error != 2'd0);
    end

    assign o_inst_valid = (r_count != '0) && (r_state != ST_FAULT);
    assign o_inst_pc    = o_inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'd0;
    assign o_inst_data  = o_inst_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
    assign o_dreq_ready = w_data_issue;

    assign o_cache_command = w_data_issue ? (i_dreq_write ? 3'd3 : 3'd2)
                           : (w_inst_issue ? 3'd1 : 3'd0);
    assign o_cache_inst_addr = r_pc;

    // The cache samples the command in the issue cycle, so the request fields
    // are passed straight through then and held from the latch afterwards.
    assign o_cache_data_addr  = w_data_issue ? i_dreq_addr  : r_data_addr;
    assign o_cache_data_wdata = w_data_issue ? i_dreq_wdata : r_data_wdata;
    assign o_cache_data_wstrb = w_data_issue ? i_dreq_wstrb : r_data_wstrb;

    assign o_dresp_valid = r_dresp_valid;
    assign o_dresp_rdata = r_dresp_rdata;
    assign o_fault       = r_fault;
    assign o_fault_code  = r_fault_code;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_pc;
            r_fifo_data[r_wr_ptr] <= i_cache_inst_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_data_addr   <= '0;
            r_data_wdata  <= '0;
            r_data_wstrb  <= '0;
            r_data_write  <= 1'b0;
            r_dresp_valid <= 1'b0;
            r_dresp_rdata <= '0;
            r_fault       <= 1'b0;
            r_fault_code  <= '0;
        end else begin
            r_dresp_valid <= 1'b0;

            if (w_flush) begin
                r_pc <= {i_redirect_pc[31:2], 2'b00};
            end else if (w_hit) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_data_issue) begin
                r_data_addr  <= i_dreq_addr;
                r_data_wdata <= i_dreq_wdata;
                r_data_wstrb <= i_dreq_wstrb;
                r_data_write <= i_dreq_write;
            end

            // An error overrides every state, including a completing data op.
            if (w_error) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
                if (!r_fault) r_fault_code <= i_cache_error;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_data_issue) begin
                            r_state <= ST_WAIT_DATA;
                        end else if (w_inst_issue && !i_cache_hit) begin
                            r_state <= ST_WAIT_INST;
                        end
                    end
                    ST_WAIT_INST: begin
                        if (i_cache_ready) r_state <= ST_FETCH;
                    end
                    ST_WAIT_DATA: begin
                        if (i_cache_ready) begin
                            r_dresp_valid <= 1'b1;
                            r_dresp_rdata <= r_data_write ? 32'd0 : i_cache_data_rdata;
                            r_state       <= ST_FETCH;
                        end
                    end
                    ST_FAULT: r_state <= ST_FAULT;
                    default:  r_state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_frontend.sv
// Scoreboard bench for fetch_frontend: a scripted cache model drives hits, misses,
// data ops and errors; expected instructions/responses are queued and checked on output.
`timescale 1ns/1ps
module tb_fetch_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst_pc;
    logic [31:0] o_inst_data;
    logic        i_dreq_valid;
    logic        o_dreq_ready;
    logic        i_dreq_write;
    logic [31:0] i_dreq_addr;
    logic [31:0] i_dreq_wdata;
    logic [3:0]  i_dreq_wstrb;
    logic        o_dresp_valid;
    logic [31:0] o_dresp_rdata;
    logic        o_fault;
    logic [1:0]  o_fault_code;
    logic [2:0]  o_cache_command;
    logic        i_cache_ready;
    logic        i_cache_hit;
    logic [31:0] o_cache_inst_addr;
    logic [31:0] o_cache_data_addr;
    logic [31:0] o_cache_data_wdata;
    logic [3:0]  o_cache_data_wstrb;
    logic [31:0] i_cache_inst_rdata;
    logic [31:0] i_cache_data_rdata;
    logic [1:0]  i_cache_error;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    inst_t       inst_q[$];
    logic [31:0] dresp_q[$];
    inst_t       exp_inst;
    logic [31:0] exp_rdata;
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          dresp_seen = 0;
    int          n_evt;
    int          dresp_before;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'd7) + 32'h1357_9BDF;
    endfunction

    assign i_cache_inst_rdata = inst_of(o_cache_inst_addr);

    fetch_frontend #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_redirect_valid   (i_redirect_valid),
        .i_redirect_pc      (i_redirect_pc),
        .o_inst_valid       (o_inst_valid),
        .i_inst_ready       (i_inst_ready),
        .o_inst_pc          (o_inst_pc),
        .o_inst_data        (o_inst_data),
        .i_dreq_valid       (i_dreq_valid),
        .o_dreq_ready       (o_dreq_ready),
        .i_dreq_write       (i_dreq_write),
        .i_dreq_addr        (i_dreq_addr),
        .i_dreq_wdata       (i_dreq_wdata),
        .i_dreq_wstrb       (i_dreq_wstrb),
        .o_dresp_valid      (o_dresp_valid),
        .o_dresp_rdata      (o_dresp_rdata),
        .o_fault            (o_fault),
        .o_fault_code       (o_fault_code),
        .o_cache_command    (o_cache_command),
        .i_cache_ready      (i_cache_ready),
        .i_cache_hit        (i_cache_hit),
        .o_cache_inst_addr  (o_cache_inst_addr),
        .o_cache_data_addr  (o_cache_data_addr),
        .o_cache_data_wdata (o_cache_data_wdata),
        .o_cache_data_wstrb (o_cache_data_wstrb),
        .i_cache_inst_rdata (i_cache_inst_rdata),
        .i_cache_data_rdata (i_cache_data_rdata),
        .i_cache_error      (i_cache_error)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        inst_q.push_back('{pc: pc, data: inst_of(pc)});
    endtask

    // Output monitor: every decode pop and every data response is a transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_inst_valid && i_inst_ready) begin
                $display("inst pop  pc=0x%08h data=0x%08h", o_inst_pc, o_inst_data);
                chk_eq("inst_expected", 32'(inst_q.size() != 0), 32'd1);
                if (inst_q.size() != 0) begin
                    exp_inst = inst_q.pop_front();
                    chk_eq("inst_pc", o_inst_pc, exp_inst.pc);
                    chk_eq("inst_data", o_inst_data, exp_inst.data);
                end
            end
            if (o_dresp_valid) begin
                dresp_seen++;
                $display("dresp     rdata=0x%08h", o_dresp_rdata);
                chk_eq("dresp_expected", 32'(dresp_q.size() != 0), 32'd1);
                if (dresp_q.size() != 0) begin
                    exp_rdata = dresp_q.pop_front();
                    chk_eq("dresp_rdata", o_dresp_rdata, exp_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0; i_inst_ready = 1'b0;
        i_dreq_valid = 1'b0; i_dreq_write = 1'b0; i_dreq_addr = '0; i_dreq_wdata = '0;
        i_dreq_wstrb = '0; i_cache_ready = 1'b0; i_cache_hit = 1'b0;
        i_cache_data_rdata = '0; i_cache_error = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_cmd", 32'(o_cache_command), 32'd0);
        chk_eq("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        chk_eq("rst_fault", 32'(o_fault), 32'd0);
        chk_eq("rst_dresp", 32'(o_dresp_valid), 32'd0);
        chk_eq("rst_pc", o_cache_inst_addr, 32'h0);
        cyc();

        // Back-to-back hits from RESET_PC
        rst_n = 1'b1; i_cache_ready = 1'b1; i_cache_hit = 1'b1; i_inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_inst(32'(4 * k));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_eq("s1_cmd", 32'(o_cache_command), 32'd1);
            chk_eq("s1_addr", o_cache_inst_addr, 32'(4 * k));
            cyc();
        end
        i_cache_ready = 1'b0;
        wait_cycles(3);
        chk_eq("s1_drained", 32'(inst_q.size()), 32'd0);

        // Miss at 0x40 with a long busy period, then a single re-issue
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h40;
        cyc();
        i_redirect_valid = 1'b0; i_cache_ready = 1'b1; i_cache_hit = 1'b0;
        expect_inst(32'h40);
        @(negedge clk);
        chk_eq("s2_miss_cmd", 32'(o_cache_command), 32'd1);
        chk_eq("s2_miss_addr", o_cache_inst_addr, 32'h40);
        cyc();
        i_cache_ready = 1'b0;
        n_evt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_cache_command != 3'd0 || o_inst_valid) n_evt++;
            cyc();
        end
        chk_eq("s2_busy_quiet", 32'(n_evt), 32'd0);
        i_cache_ready = 1'b1; i_cache_hit = 1'b1;
        @(negedge clk);
        chk_eq("s2_refill_cmd", 32'(o_cache_command), 32'd0);
        cyc();
        @(negedge clk);
        chk_eq("s2_reissue_cmd", 32'(o_cache_command), 32'd1);
        chk_eq("s2_reissue_addr", o_cache_inst_addr, 32'h40);
        cyc();
        i_cache_ready = 1'b0;
        wait_cycles(3);
        chk_eq("s2_drained", 32'(inst_q.size()), 32'd0);

        // Decode stalled: FIFO fills to depth, one pop admits one fetch
        i_inst_ready = 1'b0; i_cache_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_inst(32'h44 + 32'(4 * k));
        n_evt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_cache_command == 3'd1) n_evt++;
            cyc();
        end
        chk_eq("s3_fill_fetches", 32'(n_evt), 32'd4);
        i_inst_ready = 1'b1;
        @(negedge clk);
        chk_eq("s3_pop_cycle_cmd", 32'(o_cache_command), 32'd0);
        cyc();
        i_inst_ready = 1'b0;
        n_evt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_cache_command == 3'd1) n_evt++;
            cyc();
        end
        chk_eq("s3_refill_fetches", 32'(n_evt), 32'd1);
        i_cache_ready = 1'b0; i_inst_ready = 1'b1;
        wait_cycles(6);
        chk_eq("s3_drained", 32'(inst_q.size()), 32'd0);

        // Load takes priority over fetch; fetch resumes at the same pc
        i_cache_ready = 1'b1; i_dreq_valid = 1'b1; i_dreq_write = 1'b0; i_dreq_addr = 32'h1000;
        dresp_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        chk_eq("s4_load_cmd", 32'(o_cache_command), 32'd2);
        chk_eq("s4_dreq_ready", 32'(o_dreq_ready), 32'd1);
        cyc();
        i_dreq_valid = 1'b0; i_dreq_addr = '0; i_cache_ready = 1'b0;
        @(negedge clk);
        chk_eq("s4_wait_cmd", 32'(o_cache_command), 32'd0);
        chk_eq("s4_data_addr", o_cache_data_addr, 32'h1000);
        wait_cycles(3);
        i_cache_ready = 1'b1; i_cache_data_rdata = 32'hCAFE_F00D;
        expect_inst(32'h58);
        @(negedge clk);
        chk_eq("s4_done_cmd", 32'(o_cache_command), 32'd0);
        cyc();
        i_cache_data_rdata = '0;
        @(negedge clk);
        chk_eq("s4_dresp_pulse", 32'(o_dresp_valid), 32'd1);
        chk_eq("s4_resume_cmd", 32'(o_cache_command), 32'd1);
        chk_eq("s4_resume_addr", o_cache_inst_addr, 32'h58);
        cyc();
        i_cache_ready = 1'b0;
        @(negedge clk);
        chk_eq("s4_dresp_single", 32'(o_dresp_valid), 32'd0);
        wait_cycles(3);
        chk_eq("s4_inst_drained", 32'(inst_q.size()), 32'd0);

        // Store: fields latched through the wait, response data is zero
        i_cache_ready = 1'b1; i_dreq_valid = 1'b1; i_dreq_write = 1'b1;
        i_dreq_addr = 32'h2000; i_dreq_wdata = 32'h1122_3344; i_dreq_wstrb = 4'b0101;
        dresp_q.push_back(32'h0);
        @(negedge clk);
        chk_eq("s4_store_cmd", 32'(o_cache_command), 32'd3);
        cyc();
        i_dreq_valid = 1'b0; i_dreq_write = 1'b0; i_dreq_addr = '0; i_dreq_wdata = '0;
        i_dreq_wstrb = '0; i_cache_ready = 1'b0;
        @(negedge clk);
        chk_eq("s4_store_addr", o_cache_data_addr, 32'h2000);
        chk_eq("s4_store_wdata", o_cache_data_wdata, 32'h1122_3344);
        chk_eq("s4_store_wstrb", 32'(o_cache_data_wstrb), 32'h5);
        cyc();
        i_cache_ready = 1'b1; i_cache_data_rdata = 32'hFFFF_FFFF;
        cyc();
        i_cache_ready = 1'b0; i_cache_data_rdata = '0;
        wait_cycles(3);
        chk_eq("s4_dresp_drained", 32'(dresp_q.size()), 32'd0);

        // Redirect to an unaligned pc during a hit: FIFO flushed, hit dropped
        i_inst_ready = 1'b0; i_cache_ready = 1'b1; i_cache_hit = 1'b1;
        wait_cycles(2);
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h203;
        @(negedge clk);
        chk_eq("s5_hit_addr", o_cache_inst_addr, 32'h64);
        cyc();
        i_redirect_valid = 1'b0; i_inst_ready = 1'b1;
        expect_inst(32'h200);
        @(negedge clk);
        chk_eq("s5_flushed", 32'(o_inst_valid), 32'd0);
        chk_eq("s5_next_cmd", 32'(o_cache_command), 32'd1);
        chk_eq("s5_next_addr", o_cache_inst_addr, 32'h200);
        cyc();
        i_cache_ready = 1'b0;
        wait_cycles(3);
        chk_eq("s5_drained", 32'(inst_q.size()), 32'd0);

        // Cache error while a load is outstanding
        i_cache_ready = 1'b1; i_dreq_valid = 1'b1; i_dreq_write = 1'b0; i_dreq_addr = 32'h3000;
        cyc();
        i_dreq_valid = 1'b0; i_cache_ready = 1'b0;
        wait_cycles(2);
        dresp_before = dresp_seen;
        i_cache_ready = 1'b1; i_cache_error = 2'd1; i_cache_data_rdata = 32'h1234_5678;
        cyc();
        i_cache_error = 2'd0;
        @(negedge clk);
        chk_eq("s6_fault", 32'(o_fault), 32'd1);
        chk_eq("s6_fault_code", 32'(o_fault_code), 32'd1);
        i_dreq_valid = 1'b1;
        n_evt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_cache_command != 3'd0 || o_dreq_ready || o_inst_valid || o_dresp_valid) n_evt++;
            cyc();
        end
        chk_eq("s6_quiet", 32'(n_evt), 32'd0);
        chk_eq("s6_no_dresp", 32'(dresp_seen), 32'(dresp_before));
        chk_eq("s6_fault_sticky", 32'(o_fault), 32'd1);
        i_dreq_valid = 1'b0; i_cache_ready = 1'b0; i_cache_data_rdata = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("s6_fault_cleared", 32'(o_fault), 32'd0);
        cyc();
        rst_n = 1'b1; i_cache_ready = 1'b1;
        expect_inst(32'h0);
        @(negedge clk);
        chk_eq("s6_refetch_cmd", 32'(o_cache_command), 32'd1);
        chk_eq("s6_refetch_addr", o_cache_inst_addr, 32'h0);
        cyc();
        i_cache_ready = 1'b0;
        wait_cycles(3);
        chk_eq("s6_drained", 32'(inst_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
